// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared between the store decoder and the store unit.
//   - Store width encodings carried on st_ctrl (SB/SH/SW).
//   - Store unit FSM state enum.
//   - store_mask(): byte mask for a store width, before lane shifting.
package riscv_pkg;

    localparam logic [2:0] CtrlSb = 3'd0;
    localparam logic [2:0] CtrlSh = 3'd1;
    localparam logic [2:0] CtrlSw = 3'd2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLo   = 2'd1,
        StHi   = 2'd2,
        StResp = 2'd3
    } st_state_e;

    // Unknown encodings fall back to a single byte.
    function automatic logic [3:0] store_mask(input logic [2:0] ctrl);
        logic [3:0] mask;
        case (ctrl)
            CtrlSh:  mask = 4'b0011;
            CtrlSw:  mask = 4'b1111;
            default: mask = 4'b0001;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/store_unit_ctrl_if.sv
// store_unit_ctrl_if: store request/response handshake plus memory write bus.
//   st_valid/st_ready/st_addr/st_data/st_ctrl : store request from execute
//   st_done/st_err                            : completion pulse and timeout flag
//   mem_req/mem_addr/mem_wdata/mem_be/mem_ack : word-aligned memory write access
// master : the store unit controller side.
// slave  : the pipeline + memory side (environment).
interface store_unit_ctrl_if;

    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_ctrl;
    logic        st_done;
    logic        st_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    modport master (
        input  st_valid, st_addr, st_data, st_ctrl, mem_ack,
        output st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output st_valid, st_addr, st_data, st_ctrl, mem_ack,
        input  st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/store_lane_align.sv
// store_lane_align: purely combinational byte-lane alignment for a store.
//   i_ctrl   : store width (SB/SH/SW, others treated as SB)
//   i_off    : byte offset within the word (addr[1:0])
//   i_data   : store data, right-justified
//   o_be8    : byte enables over two consecutive words ([3:0] low, [7:4] high)
//   o_data64 : write data over the same two-word window
module store_lane_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_ctrl,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_data,
    output logic [7:0]  o_be8,
    output logic [63:0] o_data64
);

    always_comb begin
        o_be8    = {4'b0000, store_mask(i_ctrl)} << i_off;
        o_data64 = {32'h0, i_data} << {i_off, 3'b000};
    end

endmodule

// File: rtl/store_unit_ctrl.sv
// store_unit_ctrl: issues a store as one or two word-aligned memory writes.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : store_unit_ctrl_if.master (store handshake + memory write bus)
// A store whose bytes cross a word boundary is split into an LO access at the
// aligned address and an HI access at the next word. Each access is aborted
// after TIMEOUT_CYCLES cycles without mem_ack, completing the store with st_err.
module store_unit_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    store_unit_ctrl_if.master bus
);

    localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    st_state_e       r_state;
    st_state_e       w_state_next;
    logic [31:0]     r_addr;
    logic [31:0]     r_data;
    logic [2:0]      r_ctrl;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_next;
    logic            r_err;
    logic            w_err_next;

    logic [7:0]      w_be8;
    logic [63:0]     w_data64;
    logic [31:0]     w_word_addr;
    logic            w_accept;

    logic            w_st_ready;
    logic            w_st_done;
    logic            w_st_err;
    logic            w_mem_req;
    logic [31:0]     w_mem_addr;
    logic [31:0]     w_mem_wdata;
    logic [3:0]      w_mem_be;

    store_lane_align u_lane_align (
        .i_ctrl   (r_ctrl),
        .i_off    (r_addr[1:0]),
        .i_data   (r_data),
        .o_be8    (w_be8),
        .o_data64 (w_data64)
    );

    assign w_word_addr = {r_addr[31:2], 2'b00};
    assign w_accept    = bus.st_valid && w_st_ready;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_err_next   = r_err;
        w_st_ready   = 1'b0;
        w_st_done    = 1'b0;
        w_st_err     = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_addr   = 32'h0;
        w_mem_wdata  = 32'h0;
        w_mem_be     = 4'h0;

        case (r_state)
            StIdle: begin
                w_st_ready = 1'b1;
                if (bus.st_valid) begin
                    w_state_next = StLo;
                    w_cnt_next   = '0;
                    w_err_next   = 1'b0;
                end
            end
            StLo: begin
                w_mem_req   = 1'b1;
                w_mem_addr  = w_word_addr;
                w_mem_be    = w_be8[3:0];
                w_mem_wdata = w_data64[31:0];
                if (bus.mem_ack) begin
                    w_cnt_next   = '0;
                    w_state_next = (w_be8[7:4] != 4'h0) ? StHi : StResp;
                end else if (r_cnt == CntLast) begin
                    // Timed out: HI is skipped even for a split store.
                    w_err_next   = 1'b1;
                    w_state_next = StResp;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StHi: begin
                w_mem_req   = 1'b1;
                w_mem_addr  = w_word_addr + 32'd4;  // wraps past 0xFFFFFFFC
                w_mem_be    = w_be8[7:4];
                w_mem_wdata = w_data64[63:32];
                if (bus.mem_ack) begin
                    w_state_next = StResp;
                end else if (r_cnt == CntLast) begin
                    w_err_next   = 1'b1;
                    w_state_next = StResp;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StResp: begin
                w_st_done    = 1'b1;
                w_st_err     = r_err;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the state, so an async reset drops mem_req at once.
    assign bus.st_ready  = w_st_ready;
    assign bus.st_done   = w_st_done;
    assign bus.st_err    = w_st_err;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.mem_be    = w_mem_be;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_addr  <= 32'h0;
            r_data  <= 32'h0;
            r_ctrl  <= CtrlSb;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
            if (w_accept) begin
                r_addr <= bus.st_addr;
                r_data <= bus.st_data;
                r_ctrl <= bus.st_ctrl;
            end
        end
    end

endmodule

// File: doc/store_unit_ctrl.md
STORE_UNIT_CTRL -- requirements
Module: store_unit_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles one memory access may wait for mem_ack before it is aborted.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port st_valid, input, 1, store request from the decode/execute stage.
REQ-005 SHALL have port st_ready, output, 1, controller can accept a store.
REQ-006 SHALL have port st_addr, input, 32, effective byte address (rs1 + imm).
REQ-007 SHALL have port st_data, input, 32, rs2 value, with the store data in the low bytes.
REQ-008 SHALL have port st_ctrl, input, 3, store width: SB, SH or SW encoding.
REQ-009 SHALL have port st_done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port st_err, output, 1, valid only with st_done; 1 means the store timed out.
REQ-011 SHALL have port mem_req, output, 1, memory write request.
REQ-012 SHALL have port mem_addr, output, 32, word-aligned address; bits [1:0] are always 0.
REQ-013 SHALL have port mem_wdata, output, 32, lane-aligned write data.
REQ-014 SHALL have port mem_be, output, 4, byte enables; bit i enables byte lane i.
REQ-015 SHALL have port mem_ack, input, 1, memory accepted the current access.

Function
REQ-016 SHALL implement FSM states IDLE, LO, HI and RESP; st_ready SHALL be 1 only in IDLE.
REQ-017 SHALL accept a store when st_valid && st_ready, latch addr/data/ctrl and go to LO on the next edge.
REQ-018 SHALL derive the byte mask as SB=4'b0001, SH=4'b0011, SW=4'b1111; st_ctrl values other than SH/SW SHALL be treated as SB.
REQ-019 SHALL form, with off=addr[1:0]: be8 = mask<<off (8 bits) and data64 = data<<(8*off) (64 bits).
REQ-020 In LO, SHALL drive mem_addr={addr[31:2],2'b00}, mem_be=be8[3:0], mem_wdata=data64[31:0].
REQ-021 In HI, SHALL drive mem_addr={addr[31:2],2'b00}+4, with 32-bit wrap-around (0xFFFFFFFC -> 0x0), mem_be=be8[7:4], mem_wdata=data64[63:32].
REQ-022 SHALL assert mem_req in LO and HI only, and hold mem_addr, mem_wdata and mem_be stable until mem_ack.
REQ-023 On mem_ack in LO, SHALL go to HI if be8[7:4]!=0, otherwise to RESP; on mem_ack in HI, SHALL go to RESP.
REQ-024 SHALL ignore mem_ack while mem_req=0.
REQ-025 SHALL reset a wait counter on entry to LO and to HI; if it reaches TIMEOUT_CYCLES without mem_ack, SHALL deassert mem_req and go to RESP with the error flag set; the HI access is skipped after an LO timeout.
REQ-026 In RESP, SHALL assert st_done=1 for exactly one cycle, with st_err=error flag, then go to IDLE.
REQ-027 SHALL have minimum latency accept(cycle 0) -> mem_req(cycle 1) -> st_done(cycle 2) when mem_ack is present in cycle 1; a split store adds one cycle per access.
REQ-028 st_done, st_err and mem_req SHALL be 0 outside the states defined above.

Reset
REQ-029 While rst_n=0, SHALL force: state=IDLE, st_ready=1, st_done=0, st_err=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, counter=0, error flag=0.
REQ-030 Reset asserted mid-access SHALL drop mem_req immediately, without waiting for a clock edge; the in-flight store is discarded with no st_done.

Structure
REQ-031 SHALL take the SB/SH/SW encodings (SB=3'd0, SH=3'd1, SW=3'd2) and the FSM state enum from a shared package (riscv_pkg), which is common with the store decoder.
REQ-032 SHALL place mask/shift generation in one combinational sub-module, store_lane_align (inputs ctrl, off, data; outputs be8, data64).

Verification
REQ-033 SW 0xDEADBEEF @0x100, mem_ack in the first req cycle -> one access at 0x100, be=1111, wdata=0xDEADBEEF; st_done in cycle 2, st_err=0.
REQ-034 SB 0x000000AB @0x203 -> one access at 0x200, be=1000, wdata=0xAB000000.
REQ-035 SW 0x11223344 @0x102 -> LO: 0x100, be=1100, wdata=0x33440000; then HI: 0x104, be=0011, wdata=0x00001122; one st_done.
REQ-036 SH 0xBEEF @0xFFFFFFFF -> LO: 0xFFFFFFFC, be=1000, wdata=0xEF000000; HI: 0x00000000, be=0001, wdata=0x000000BE.
REQ-037 mem_ack never asserted, TIMEOUT_CYCLES=4 -> mem_req falls after 4 cycles; st_done=1 with st_err=1; st_ready returns.
REQ-038 rst_n pulled low while mem_req=1 in HI -> mem_req=0 immediately; no st_done; next store after reset completes normally.
